// File: rtl/vga_colormap_display.sv
// VGA timing generator with streaming frame-store fetch and heat-map colouring.
// Sync, blank and RGB leave through matched pipelines so every DAC pin stays aligned.
module vga_colormap_display #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SW   = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SW   = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = $clog2(H_ACT*V_ACT)
) (
  input  logic              i_clk_25M,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_min,
  input  logic [3:0]        i_shift,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_VGA_CLK,
  output logic              o_VGA_HS,
  output logic              o_VGA_VS,
  output logic              o_VGA_BLANK_N,
  output logic              o_VGA_SYNC_N,
  output logic [7:0]        o_VGA_R,
  output logic [7:0]        o_VGA_G,
  output logic [7:0]        o_VGA_B,
  output logic              o_frame_done
);

  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int L     = RD_LAT + 2;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
  localparam logic [HW-1:0] H_SS    = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_SE    = HW'(H_ACT + H_FP + H_SW);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
  localparam logic [VW-1:0] V_SS    = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_SE    = VW'(V_ACT + V_FP + V_SW);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              fd_q, fd_d;
  logic              start_s, h_end_s, v_end_s;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [3:0]        shift_q, shift_d;
  logic [L-1:0]      hs_dl_q, hs_dl_d, vs_dl_q, vs_dl_d, bl_dl_q, bl_dl_d;
  logic              hs_raw_s, vs_raw_s;
  logic [DATA_W-1:0] diff_s, scaled_s;
  logic [9:0]        n_q, n_d;
  logic [23:0]       rgb_q, rgb_d;

  function automatic logic [23:0] colour_map(input logic [1:0] mode, input logic [9:0] n);
    logic [7:0]  f;
    logic [23:0] c;
    begin
      f = n[7:0];
      case (mode)
        2'd0: begin
          if (!n[9]) begin
            c = {8'd0, n[8:1], 8'd255 - n[8:1]};
          end else begin
            c = {n[8:1], 8'd255 - n[8:1], 8'd0};
          end
        end
        2'd1: begin
          case (n[9:8])
            2'd0:    c = {8'd0, 8'd0, f};
            2'd1:    c = {8'd0, f, 8'd255 - f};
            2'd2:    c = {f, 8'd255 - f, 8'd0};
            default: c = {8'd255, f, f};
          endcase
        end
        default: c = {3{n[9:2]}};
      endcase
      colour_map = c;
    end
  endfunction

  assign h_end_s = (h_q == H_LAST);
  assign v_end_s = (v_q == V_LAST);

  // Frame walker: IDLE/RUN control with pixel and line counters.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (i_enable) begin
          state_d = S_RUN;
          start_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!h_end_s) begin
          h_d = h_q + HW'(1);
        end else begin
          h_d = '0;
          if (!v_end_s) begin
            v_d = v_q + VW'(1);
          end else begin
            v_d = '0;
            if (i_enable) begin
              start_s = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // Fetch, shadow settings, sync delay line and the two pixel pipeline stages.
  always_comb begin
    rd_en_d = (state_d == S_RUN) && (h_d < H_ACT_C) && (v_d < V_ACT_C);
    fd_d    = (state_d == S_RUN) && (h_d == H_LAST) && (v_d == V_LAST);

    if ((state_d != S_RUN) || start_s) begin
      addr_d = '0;
    end else if (rd_en_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end

    if (start_s) begin
      mode_d  = i_mode;
      min_d   = i_min;
      shift_d = i_shift;
    end else begin
      mode_d  = mode_q;
      min_d   = min_q;
      shift_d = shift_q;
    end

    hs_raw_s = ((state_q == S_RUN) && (h_q >= H_SS) && (h_q < H_SE)) ? HS_POL : ~HS_POL;
    vs_raw_s = ((state_q == S_RUN) && (v_q >= V_SS) && (v_q < V_SE)) ? VS_POL : ~VS_POL;
    hs_dl_d  = {hs_dl_q[L-2:0], hs_raw_s};
    vs_dl_d  = {vs_dl_q[L-2:0], vs_raw_s};
    bl_dl_d  = {bl_dl_q[L-2:0], rd_en_q};

    diff_s   = i_rd_data - min_q;
    scaled_s = diff_s >> shift_q;
    if (i_rd_data < min_q) begin
      n_d = 10'd0;
    end else if (scaled_s > DATA_W'(1023)) begin
      n_d = 10'd1023;
    end else begin
      n_d = scaled_s[9:0];
    end

    // Blank flag one stage early lines up with n_q entering the colour stage.
    if (bl_dl_q[L-2]) begin
      rgb_d = colour_map(mode_q, n_q);
    end else begin
      rgb_d = 24'd0;
    end
  end

  // State and datapath registers; reset drops every output at once.
  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      fd_q    <= 1'b0;
      mode_q  <= 2'd0;
      min_q   <= '0;
      shift_q <= 4'd0;
      hs_dl_q <= {L{~HS_POL}};
      vs_dl_q <= {L{~VS_POL}};
      bl_dl_q <= '0;
      n_q     <= 10'd0;
      rgb_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      fd_q    <= fd_d;
      mode_q  <= mode_d;
      min_q   <= min_d;
      shift_q <= shift_d;
      hs_dl_q <= hs_dl_d;
      vs_dl_q <= vs_dl_d;
      bl_dl_q <= bl_dl_d;
      n_q     <= n_d;
      rgb_q   <= rgb_d;
    end
  end

  assign o_rd_en       = rd_en_q;
  assign o_rd_addr     = addr_q;
  assign o_frame_done  = fd_q;
  assign o_VGA_CLK     = i_clk_25M;
  assign o_VGA_SYNC_N  = 1'b0;
  assign o_VGA_HS      = hs_dl_q[L-1];
  assign o_VGA_VS      = vs_dl_q[L-1];
  assign o_VGA_BLANK_N = bl_dl_q[L-1];
  assign o_VGA_R       = rgb_q[23:16];
  assign o_VGA_G       = rgb_q[15:8];
  assign o_VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_colormap_display.sv
// Directed bench for vga_colormap_display on a shrunken 24x10 raster.
// A two-stage memory model returns per-address samples with the read latency.
module tb_vga_colormap_display;
  localparam int H_ACT = 16, H_FP = 2, H_SW = 3, H_BP = 3;
  localparam int V_ACT = 6, V_FP = 1, V_SW = 2, V_BP = 1;
  localparam int DATA_W = 16, RD_LAT = 2, L = RD_LAT + 2;
  localparam int ADDR_W = $clog2(H_ACT*V_ACT);

  logic              clk = 1'b0;
  logic              rst, en;
  logic [1:0]        mode;
  logic [15:0]       min_v;
  logic [3:0]        shift;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              vga_clk, hs, vs, blank_n, sync_n, fd;
  logic [7:0]        r, g, b;
  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  logic [15:0]       pipe0 = 16'd0, pipe1 = 16'd0;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, first_rd = -1, first_blank = -1, first_hs_fall = -1;
  int hs_low = 0, hs_w = 0, hs_fall_t = -1, hs_per = 0;
  int vs_low = 0, vs_w = 0, vs_fall_t = -1, vs_per = 0;
  int fd_t = -1, fd_per = 0, rd_cnt = 0, rd_frame = 0, exp_addr = 0, addr_err = 0;
  logic hs_p = 1'b1, vs_p = 1'b1;
  logic [23:0] px;
  logic        pb;
  bit          seen;

  vga_colormap_display #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk_25M(clk), .i_rst(rst), .i_enable(en), .i_mode(mode), .i_min(min_v),
    .i_shift(shift), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_VGA_CLK(vga_clk), .o_VGA_HS(hs), .o_VGA_VS(vs), .o_VGA_BLANK_N(blank_n),
    .o_VGA_SYNC_N(sync_n), .o_VGA_R(r), .o_VGA_G(g), .o_VGA_B(b), .o_frame_done(fd)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    pipe0 <= mem[rd_addr];
    pipe1 <= pipe0;
  end
  assign rd_data = pipe1;

  // Raster monitor: sync widths/periods, fetch ordering and first-event times.
  always @(negedge clk) begin
    cyc  <= cyc + 1;
    hs_p <= hs;
    vs_p <= vs;
    if (rst) begin
      exp_addr <= 0;
      rd_cnt   <= 0;
    end else begin
      if (rd_en) begin
        if (first_rd < 0) first_rd <= cyc;
        if (rd_addr != ADDR_W'(exp_addr)) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 1;
        rd_cnt   <= rd_cnt + 1;
      end
      if (blank_n && first_blank < 0) first_blank <= cyc;
      if (!hs) hs_low <= hs_low + 1;
      else begin
        if (!hs_p) hs_w <= hs_low;
        hs_low <= 0;
      end
      if (hs_p && !hs) begin
        if (first_hs_fall < 0) first_hs_fall <= cyc;
        if (hs_fall_t >= 0) hs_per <= cyc - hs_fall_t;
        hs_fall_t <= cyc;
      end
      if (!vs) vs_low <= vs_low + 1;
      else begin
        if (!vs_p) vs_w <= vs_low;
        vs_low <= 0;
      end
      if (vs_p && !vs) begin
        if (vs_fall_t >= 0) vs_per <= cyc - vs_fall_t;
        vs_fall_t <= cyc;
      end
      if (fd) begin
        rd_frame <= rd_cnt;
        rd_cnt   <= 0;
        exp_addr <= 0;
        if (fd_t >= 0) fd_per <= cyc - fd_t;
        fd_t <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic get_pix(input int addr, output logic [23:0] rgb, output logic blk);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      hit = rd_en && (rd_addr == ADDR_W'(addr));
    end
    check_eq($sformatf("fetch_%0d", addr), 32'(hit), 32'd1);
    repeat (L) @(negedge clk);
    rgb = {r, g, b};
    blk = blank_n;
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 16'd0;
    mem[0]  = 16'd0;     mem[8]  = 16'd32767; mem[16] = 16'd65535;
    mem[24] = 16'd1000;  mem[40] = 16'd40000; mem[64] = 16'h0140;
    mem[72] = 16'd5000;  mem[80] = 16'd500;   mem[88] = 16'd1100;
    rst = 1'b1; en = 1'b0; mode = 2'd0; min_v = 16'd0; shift = 4'd6;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_hs", 32'(hs), 32'd1);
    check_eq("rst_vs", 32'(vs), 32'd1);
    check_eq("rst_blank", 32'(blank_n), 32'd0);
    check_eq("rst_rgb", 32'({r, g, b}), 32'd0);
    check_eq("rst_rd_en", 32'(rd_en), 32'd0);
    check_eq("rst_fd", 32'(fd), 32'd0);
    check_eq("sync_n", 32'(sync_n), 32'd0);
    check_eq("vga_clk", 32'(vga_clk), 32'(clk));

    // Frame 1: mode 0, min 0, shift 6.
    en = 1'b1;
    get_pix(0, px, pb);  check_eq("f1_a0", 32'(px), 32'h0000FF);
    check_eq("f1_a0_blank", 32'(pb), 32'd1);
    get_pix(8, px, pb);  check_eq("f1_a8", 32'(px), 32'h00FF00);
    get_pix(16, px, pb); check_eq("f1_a16", 32'(px), 32'hFF0000);
    get_pix(24, px, pb); check_eq("f1_a24", 32'(px), 32'h0007F8);
    get_pix(40, px, pb); check_eq("f1_a40", 32'(px), 32'h38C700);
    mode = 2'd1; shift = 4'd0;
    get_pix(64, px, pb); check_eq("f1_a64_keep", 32'(px), 32'h0002FD);

    // Frame 2: mode 1, shift 0 taken at the frame boundary.
    get_pix(24, px, pb); check_eq("f2_a24", 32'(px), 32'hFFE8E8);
    get_pix(64, px, pb); check_eq("f2_a64", 32'(px), 32'h0040BF);
    get_pix(72, px, pb); check_eq("f2_a72", 32'(px), 32'hFFFFFF);
    mode = 2'd2; min_v = 16'd1000;

    // Frame 3: grayscale with window floor 1000, then drop enable mid-frame.
    get_pix(72, px, pb); check_eq("f3_a72_clamp", 32'(px), 32'hFFFFFF);
    get_pix(80, px, pb); check_eq("f3_a80_floor", 32'(px), 32'h000000);
    get_pix(88, px, pb); check_eq("f3_a88", 32'(px), 32'h191919);
    en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = fd;
    end
    check_eq("fd_pulse", 32'(seen), 32'd1);
    @(negedge clk);
    check_eq("fd_width", 32'(fd), 32'd0);
    repeat (L + 1) @(negedge clk);
    check_eq("idle_rd_en", 32'(rd_en), 32'd0);
    check_eq("idle_blank", 32'(blank_n), 32'd0);
    check_eq("idle_hs", 32'(hs), 32'd1);
    check_eq("idle_vs", 32'(vs), 32'd1);
    check_eq("idle_rgb", 32'({r, g, b}), 32'd0);
    check_eq("idle_addr", 32'(rd_addr), 32'd0);
    repeat (300) @(negedge clk);
    check_eq("idle_no_fetch", rd_cnt, 0);

    check_eq("blank_lat", first_blank - first_rd, 4);
    check_eq("hs_first_edge", first_hs_fall - first_rd, 22);
    check_eq("hs_width", hs_w, 3);
    check_eq("hs_period", hs_per, 24);
    check_eq("vs_width", vs_w, 48);
    check_eq("vs_period", vs_per, 240);
    check_eq("fd_period", fd_per, 240);
    check_eq("rd_per_frame", rd_frame, 96);
    check_eq("addr_order", addr_err, 0);

    // Mid-line asynchronous reset.
    en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = blank_n;
    end
    check_eq("rerun_blank", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mrst_blank", 32'(blank_n), 32'd0);
    check_eq("mrst_rgb", 32'({r, g, b}), 32'd0);
    check_eq("mrst_rd_en", 32'(rd_en), 32'd0);
    check_eq("mrst_addr", 32'(rd_addr), 32'd0);
    check_eq("mrst_hs", 32'(hs), 32'd1);
    check_eq("mrst_vs", 32'(vs), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
